vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_pixel_divider.sv | 37 +++
 rtl/vga_timing_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480 at 60 Hz driven from a 50 MHz system clock.
package vga_timing_pkg;

  localparam int unsigned CoordW = 10;

  typedef logic [CoordW-1:0] coord_t;

  localparam int unsigned DefClkDiv   = 2;
  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFp      = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBp      = 48;
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFp      = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBp      = 33;
  localparam logic        DefSyncPol  = 1'b0;

  // Total positions per line or per frame; must not exceed 1 << CoordW.
  function automatic int unsigned calc_total(input int unsigned visible,
                                             input int unsigned front_porch,
                                             input int unsigned sync_width,
                                             input int unsigned back_porch);
    return visible + front_porch + sync_width + back_porch;
  endfunction

  function automatic logic in_range(input coord_t pos, input coord_t lo, input coord_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_divider.sv
// Divides the system clock down to the pixel rate: o_tick is high on the
// last system clock of every pixel period, and permanently high when CLK_DIV is 1.
module vga_pixel_divider #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned        DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]      DMax = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_d;
  logic [DW-1:0] w_d_nxt;
  logic          w_at_max;

  assign w_at_max = (r_d == DMax);

  always_comb begin
    w_d_nxt = r_d + 1'b1;
    if (w_at_max) begin
      w_d_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= '0;
    end else begin
      r_d <= w_d_nxt;
    end
  end

  assign o_tick = w_at_max;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running x/y position, sync pulses, visible flag and
// pixel/line/frame strobes. All outputs are registered and aligned with x/y.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DefClkDiv,
  parameter int unsigned H_VISIBLE = DefHVisible,
  parameter int unsigned H_FP      = DefHFp,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BP      = DefHBp,
  parameter int unsigned V_VISIBLE = DefVVisible,
  parameter int unsigned V_FP      = DefVFp,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BP      = DefVBp,
  parameter logic        SYNC_POL  = DefSyncPol
) (
  input  logic              clk,
  input  logic              rst,
  output logic [CoordW-1:0] o_x,
  output logic [CoordW-1:0] o_y,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_video_on,
  output logic              o_pix_tick,
  output logic              o_line_start,
  output logic              o_frame_start,
  output logic [7:0]        o_frame_count
);

  localparam int unsigned HTotal = calc_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = calc_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  localparam coord_t HMax       = CoordW'(HTotal - 1);
  localparam coord_t VMax       = CoordW'(VTotal - 1);
  localparam coord_t HVis       = CoordW'(H_VISIBLE);
  localparam coord_t VVis       = CoordW'(V_VISIBLE);
  localparam coord_t HSyncStart = CoordW'(H_VISIBLE + H_FP);
  localparam coord_t HSyncStop  = CoordW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VSyncStart = CoordW'(V_VISIBLE + V_FP);
  localparam coord_t VSyncStop  = CoordW'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic       w_tick;
  coord_t     r_x;
  coord_t     r_y;
  coord_t     w_x_nxt;
  coord_t     w_y_nxt;
  logic       w_line_wrap;
  logic       w_frame_wrap;
  logic       w_hsync_nxt;
  logic       w_vsync_nxt;
  logic       w_video_on_nxt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_pix_tick;
  logic       r_line_start;
  logic       r_frame_start;
  logic [7:0] r_frame_count;

  vga_pixel_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  // Next position; y advances only on the pixel where x wraps.
  always_comb begin
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_line_wrap  = 1'b0;
    w_frame_wrap = 1'b0;
    if (w_tick) begin
      if (r_x == HMax) begin
        w_x_nxt     = '0;
        w_line_wrap = 1'b1;
        if (r_y == VMax) begin
          w_y_nxt      = '0;
          w_frame_wrap = 1'b1;
        end else begin
          w_y_nxt = r_y + 1'b1;
        end
      end else begin
        w_x_nxt = r_x + 1'b1;
      end
    end
  end

  // Decoding the next-state counters keeps sync/visible in step with x/y.
  always_comb begin
    w_hsync_nxt    = in_range(w_x_nxt, HSyncStart, HSyncStop) ? SYNC_POL : ~SYNC_POL;
    w_vsync_nxt    = in_range(w_y_nxt, VSyncStart, VSyncStop) ? SYNC_POL : ~SYNC_POL;
    w_video_on_nxt = (w_x_nxt < HVis) && (w_y_nxt < VVis);
  end

  // Reset parks the raster on the last position so the first tick lands on (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x           <= HMax;
      r_y           <= VMax;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_pix_tick    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'hFF;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_video_on    <= w_video_on_nxt;
      r_pix_tick    <= w_tick;
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_pix_tick    = r_pix_tick;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_count = r_frame_count;

endmodule
